add_serial_ctrl: RTL and testbench

ADD_SERIAL_CTRL -- requirements
Module: add_serial_ctrl

---
 rtl/add_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_add_serial_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl
//   Slice-serial adder. It computes {cout,sum} = a + b + cin one SLICE-bit
//   chunk per clock, starting with the LSB chunk. A handshake on the input
//   side starts an operation. The result is held on the output side until
//   the consumer takes it.
//
// Parameters
//   WIDTH : operand/result width in bits. Must be a multiple of SLICE.
//   SLICE : bits added per cycle.
//
// Ports
//   clk       : clock; all state changes on the rising edge.
//   rst       : asynchronous, active-high reset.
//   in_valid  : operand request valid.
//   in_ready  : block can accept operands (IDLE and not in reset).
//   a, b      : operands.
//   cin       : carry-in of the full-width add.
//   out_valid : result valid (DONE state).
//   out_ready : consumer accepts the result.
//   sum       : registered result.
//   cout      : registered carry-out.
//   busy      : high whenever the FSM is not IDLE.
module add_serial_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [SLICE:0]   slice_res;
  int               base;

  // Generate/propagate ripple across one slice. Returns {carry_out, sum}.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    logic [SLICE:0]   c;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] s;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      s[i]   = p[i] ^ c[i];
    end
    return {c[SLICE], s};
  endfunction

  always_comb begin
    base      = int'(k_q) * SLICE;
    slice_res = slice_add(a_q[base +: SLICE], b_q[base +: SLICE], carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        // in_ready is high in IDLE whenever reset is low, and reset
        // overrides every flop, so in_valid alone qualifies the accept.
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: SLICE] = slice_res[SLICE-1:0];
        carry_d              = slice_res[SLICE];
        if (k_q == K_LAST) begin
          cout_d  = slice_res[SLICE];
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        // No accept in this cycle. The next operation can only start
        // from IDLE, one cycle after the output handshake.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // in_ready is gated by rst so that it is low during reset itself.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add_serial_ctrl.sv
module tb_add_serial_ctrl;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_res   = 0;
  bit rand_rdy = 1'b0;

  logic [WIDTH:0] exp_q[$];

  add_serial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands until accepted, then push the expected result.
  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci);
    int n;
    a = ai; b = bi; cin = ci; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back({1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, ci});
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic check_latency(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    check(tag, lat, NSL);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {cout, sum}, 0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("result", {cout, sum}, e);
      end
      n_res++;
    end
  end

  // Random consumer back-pressure, driven away from the sampling edge.
  always @(posedge clk) begin
    if (rand_rdy) #1 out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int r0;
    logic [WIDTH:0] held;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Full ripple
    issue(16'hFFFF, 16'h0001, 1'b0);
    check("busy_run", busy, 1);
    check("in_ready_run", in_ready, 0);
    check_latency("lat_ripple");
    check("ripple_sum", sum, 16'h0000);
    check("ripple_cout", cout, 1);
    drain(20);

    // Carry-in only and a plain add
    issue(16'h0000, 16'h0000, 1'b1);
    check_latency("lat_cin");
    issue(16'h1234, 16'h4321, 1'b0);
    drain(20);

    // Backpressure holds the result
    out_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0);
    check_latency("lat_bp");
    held = {cout, sum};
    check("bp_value", held, 17'h10000);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold", {cout, sum}, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_busy", busy, 0);
    drain(5);

    // Inputs changing during RUN are ignored
    r0 = n_res;
    issue(16'h00FF, 16'h0001, 1'b0);
    repeat (2) begin
      in_valid = ~in_valid;
      a = 16'($urandom); b = 16'($urandom); cin = ~cin;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(20);
    repeat (6) @(posedge clk);
    #1 check("ignored_one_result", n_res - r0, 1);

    // Reset mid-operation aborts it
    r0 = n_res;
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("abort_no_valid", out_valid, 0);
    end
    check("abort_no_result", n_res - r0, 0);
    issue(16'h0002, 16'h0003, 1'b0);
    check_latency("lat_after_abort");
    check("after_abort_sum", {cout, sum}, 17'h00005);
    drain(20);

    // Random traffic with back-pressure
    r0 = n_res;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain(200);
    rand_rdy = 1'b0;
    check("random_count", n_res - r0, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
